// File: rtl/adder_pipe_n_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// Valid/ready: a beat moves only on a cycle where valid && ready are both high; the
// sender holds its payload stable while valid is high and ready is low.
interface adder_pipe_n_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero, neg
    );
endinterface

// File: rtl/adder_pipe_n.sv
// Pipelined ripple adder/subtractor: one SEG-bit slice per register stage, carry and
// zero accumulation travel with the beat; NZCV flags derived from the output stage.
module adder_pipe_n #(
    parameter int WIDTH = 8,
    parameter int SEG   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    adder_pipe_n_if.slave bus
);
    // WIDTH must be a multiple of SEG.
    localparam int NSTG = WIDTH / SEG;
    localparam int LAST = NSTG - 1;

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] b_cond;
    logic             c0;

    logic             v_q [NSTG];
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic             c_q [NSTG];
    logic             z_q [NSTG];

    logic [WIDTH-1:0] a_d [NSTG];
    logic [WIDTH-1:0] b_d [NSTG];
    logic [WIDTH-1:0] s_d [NSTG];
    logic             c_d [NSTG];
    logic             z_d [NSTG];

    // Whole pipe stalls only when the output beat is held by downstream.
    assign advance      = !(v_q[LAST] && !bus.out_ready);
    assign accept       = bus.in_valid && advance;
    assign bus.in_ready = advance;

    always_comb begin
        b_cond = bus.op[1] ? ~bus.b : bus.b;
        case (bus.op)
            2'b00:   c0 = 1'b0;
            2'b10:   c0 = 1'b1;
            default: c0 = bus.cin;
        endcase
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic             c_i;
        logic             z_i;
        logic [SEG:0]     sum;
        logic [WIDTH-1:0] s_n;

        if (k == 0) begin : g_head
            assign a_i = bus.a;
            assign b_i = b_cond;
            assign s_i = '0;
            assign c_i = c0;
            assign z_i = 1'b1;
        end else begin : g_body
            assign a_i = a_q[k-1];
            assign b_i = b_q[k-1];
            assign s_i = s_q[k-1];
            assign c_i = c_q[k-1];
            assign z_i = z_q[k-1];
        end

        assign sum = {1'b0, a_i[k*SEG +: SEG]} + {1'b0, b_i[k*SEG +: SEG]} + {{SEG{1'b0}}, c_i};

        always_comb begin
            s_n                = s_i;
            s_n[k*SEG +: SEG]  = sum[SEG-1:0];
        end

        assign a_d[k] = a_i;
        assign b_d[k] = b_i;
        assign s_d[k] = s_n;
        assign c_d[k] = sum[SEG];
        assign z_d[k] = z_i && (sum[SEG-1:0] == '0);
    end

    // Data regs load only behind a valid beat, so the output holds the last result across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                z_q[k] <= 1'b0;
            end
        end else if (advance) begin
            v_q[0] <= bus.in_valid;
            if (accept) begin
                a_q[0] <= a_d[0];
                b_q[0] <= b_d[0];
                s_q[0] <= s_d[0];
                c_q[0] <= c_d[0];
                z_q[0] <= z_d[0];
            end
            for (int k = 1; k < NSTG; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                    z_q[k] <= z_d[k];
                end
            end
        end
    end

    assign bus.out_valid = v_q[LAST];
    assign bus.s         = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.zero      = z_q[LAST];
    assign bus.neg       = s_q[LAST][WIDTH-1];
    assign bus.ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                           (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule
